helios_root_hub: RTL and testbench



---
 rtl/helios_link_pkg.sv | 23 ++
 rtl/helios_root_hub_arb.sv | 40 ++++
 rtl/helios_root_hub.sv | 140 ++++++++++++++
 tb/tb_helios_root_hub.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/helios_link_pkg.sv
// helios_link_pkg: shared 64-bit message header layout, special IDs/types and field helpers
// for the Helios parent/child links.
package helios_link_pkg;
   localparam int TYPE_LSB = 56;
   localparam int DEST_LSB = 48;
   localparam int SRC_LSB  = 40;
   localparam logic [7:0] AGG_TYPE = 8'h04;
   localparam logic [7:0] BCAST_ID = 8'hFF;

   typedef enum logic [7:0] {
      MSG_DATA   = 8'h01,
      MSG_CTRL   = 8'h02,
      MSG_STATUS = 8'h04
   } msg_type_e;

   function automatic logic [7:0] get_dest(input logic [63:0] w);
      return w[DEST_LSB +: 8];
   endfunction

   function automatic logic [7:0] get_type(input logic [63:0] w);
      return w[TYPE_LSB +: 8];
   endfunction
endpackage

// File: rtl/helios_root_hub_arb.sv
// rr_arbiter: round-robin one-hot grant; priority starts one past the last granted index
// and the pointer only moves when the grant is actually consumed.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] i_req,
   input  logic         i_adv,
   output logic [N-1:0] o_grant
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_c;
   logic          w_found;

   always_comb begin
      o_grant = '0;
      w_idx   = r_ptr;
      w_c     = r_ptr;
      w_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         w_c = PW'((int'(r_ptr) + k) % N);
         if (!w_found && i_req[w_c]) begin
            w_found      = 1'b1;
            w_idx        = w_c;
            o_grant[w_c] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_ptr <= PW'(N - 1);
      else if (i_adv && w_found)
         r_ptr <= w_idx;
   end
endmodule

// File: rtl/helios_root_hub.sv
// helios_root_hub: routes root-controller words to child lanes (unicast/broadcast) and merges
// child words round-robin upstream, folding one status report per child into one aggregate.
module helios_root_hub #(
   parameter int         NUM_CHILDREN = 4,
   parameter logic [7:0] AGG_TYPE     = helios_link_pkg::AGG_TYPE,
   parameter logic [7:0] BCAST_ID     = helios_link_pkg::BCAST_ID
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [63:0]               host_tx_data,
   input  logic                      host_tx_valid,
   output logic                      host_tx_ready,
   output logic [63:0]               host_rx_data,
   output logic                      host_rx_valid,
   input  logic                      host_rx_ready,
   output logic [64*NUM_CHILDREN-1:0] child_tx_data,
   output logic [NUM_CHILDREN-1:0]   child_tx_valid,
   input  logic [NUM_CHILDREN-1:0]   child_tx_ready,
   input  logic [64*NUM_CHILDREN-1:0] child_rx_data,
   input  logic [NUM_CHILDREN-1:0]   child_rx_valid,
   output logic [NUM_CHILDREN-1:0]   child_rx_ready,
   output logic                      dest_error
);
   import helios_link_pkg::*;

   logic [NUM_CHILDREN-1:0][63:0] r_slot_data;
   logic [NUM_CHILDREN-1:0]       r_slot_valid;
   logic [NUM_CHILDREN-1:0]       w_free;
   logic [NUM_CHILDREN-1:0]       w_load;
   logic [7:0]                    w_dest;
   logic                          w_bcast;
   logic                          w_uni;
   logic                          w_host_fire;
   logic                          r_dest_err;

   assign w_dest  = get_dest(host_tx_data);
   assign w_bcast = w_dest == BCAST_ID;
   assign w_uni   = w_dest != 8'd0 && w_dest <= 8'(NUM_CHILDREN);
   assign w_free  = ~r_slot_valid | child_tx_ready;

   always_comb begin
      w_load = '0;
      for (int i = 0; i < NUM_CHILDREN; i++)
         w_load[i] = w_bcast || (w_uni && w_dest == 8'(i + 1));
   end

   // Broadcast waits for every slot so that all lanes load on the same edge.
   assign host_tx_ready  = reset && (w_bcast ? &w_free : w_uni ? |(w_load & w_free) : 1'b1);
   assign w_host_fire    = host_tx_valid && host_tx_ready;
   assign child_tx_data  = r_slot_data;
   assign child_tx_valid = r_slot_valid;
   assign dest_error     = r_dest_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_slot_valid <= '0;
         r_slot_data  <= '0;
         r_dest_err   <= 1'b0;
      end else begin
         r_dest_err <= w_host_fire && !w_bcast && !w_uni;
         for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (w_host_fire && w_load[i]) begin
               r_slot_valid[i] <= 1'b1;
               r_slot_data[i]  <= host_tx_data;
            end else if (child_tx_ready[i]) begin
               r_slot_valid[i] <= 1'b0;
            end
         end
      end
   end

   logic [NUM_CHILDREN-1:0] w_req;
   logic [NUM_CHILDREN-1:0] w_grant;
   logic [NUM_CHILDREN-1:0] r_reported;
   logic [63:0]             w_sel;
   logic [63:0]             r_out_data;
   logic                    r_out_valid;
   logic                    r_or_acc;
   logic                    w_can_load;
   logic                    w_emit;
   logic                    w_adv;
   logic                    w_take;
   logic                    w_sel_agg;

   assign w_can_load = !r_out_valid || host_rx_ready;
   assign w_emit     = &r_reported && w_can_load;
   assign w_adv      = reset && w_can_load && !w_emit;

   // A child that already reported this round is not eligible while it presents another report.
   always_comb begin
      w_req = '0;
      for (int i = 0; i < NUM_CHILDREN; i++)
         w_req[i] = child_rx_valid[i] &&
                    !(child_rx_data[i*64 + TYPE_LSB +: 8] == AGG_TYPE && r_reported[i]);
   end

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NUM_CHILDREN; i++)
         w_sel = w_sel | ({64{w_grant[i]}} & child_rx_data[i*64 +: 64]);
   end

   rr_arbiter #(.N(NUM_CHILDREN)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_req   (w_req),
      .i_adv   (w_adv),
      .o_grant (w_grant)
   );

   assign child_rx_ready = w_grant & {NUM_CHILDREN{w_adv}};
   assign w_take         = |child_rx_ready;
   assign w_sel_agg      = get_type(w_sel) == AGG_TYPE;
   assign host_rx_data   = r_out_data;
   assign host_rx_valid  = r_out_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_reported  <= '0;
         r_or_acc    <= 1'b0;
      end else if (w_emit) begin
         r_out_valid <= 1'b1;
         r_out_data  <= {AGG_TYPE, 16'h0000, 39'b0, r_or_acc};
         r_reported  <= '0;
         r_or_acc    <= 1'b0;
      end else if (w_take && !w_sel_agg) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel;
      end else begin
         if (host_rx_ready)
            r_out_valid <= 1'b0;
         if (w_take) begin
            r_reported <= r_reported | child_rx_ready;
            r_or_acc   <= r_or_acc | w_sel[0];
         end
      end
   end
endmodule

// File: tb/tb_helios_root_hub.sv
// tb_helios_root_hub: directed stimulus against a cycle-level reference model of the hub,
// plus hand-computed expectations for routing, round-robin order and aggregation.
module tb_helios_root_hub;
   localparam int NC = 4;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [63:0]         host_tx_data, host_rx_data;
   logic                host_tx_valid, host_tx_ready, host_rx_valid, host_rx_ready;
   logic [NC*64-1:0]    child_tx_data, child_rx_data;
   logic [NC-1:0]       child_tx_valid, child_tx_ready, child_rx_valid, child_rx_ready;
   logic                dest_error;

   int errors = 0;
   int checks = 0;

   logic [63:0] hq[$];
   logic [63:0] cq[NC][$];
   logic [63:0] rx_q[$];
   int          rr_exp[8] = '{1, 2, 3, 4, 1, 2, 3, 4};

   always #5 clk = ~clk;

   helios_root_hub #(.NUM_CHILDREN(NC)) dut (
      .clk            (clk),
      .reset          (reset),
      .host_tx_data   (host_tx_data),
      .host_tx_valid  (host_tx_valid),
      .host_tx_ready  (host_tx_ready),
      .host_rx_data   (host_rx_data),
      .host_rx_valid  (host_rx_valid),
      .host_rx_ready  (host_rx_ready),
      .child_tx_data  (child_tx_data),
      .child_tx_valid (child_tx_valid),
      .child_tx_ready (child_tx_ready),
      .child_rx_data  (child_rx_data),
      .child_rx_valid (child_rx_valid),
      .child_rx_ready (child_rx_ready),
      .dest_error     (dest_error)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] agg(input int src, input bit b);
      return {8'h04, 8'h00, 8'(src), 39'b0, b};
   endfunction

   // Reference model: state of each lane, the upstream register and the report round.
   bit          m_lv[NC], m_rep[NC], e_free[NC];
   bit          m_ov, m_derr, m_acc, e_htr, e_fire, e_can, e_emit, e_all;
   logic [63:0] m_ld[NC];
   logic [63:0] m_od, m_w;
   int          m_last = NC - 1;
   int          e_d, e_g, e_c;
   logic [NC-1:0] e_crr;

   initial forever begin
      @(negedge clk);
      if (!reset) begin
         for (int i = 0; i < NC; i++) begin
            m_lv[i]  = 1'b0;
            m_rep[i] = 1'b0;
         end
         m_ov = 1'b0; m_derr = 1'b0; m_acc = 1'b0; m_last = NC - 1;
         chk("rst_child_tx_valid", child_tx_valid, '0);
         chk("rst_host_rx_valid", host_rx_valid, 0);
         chk("rst_host_tx_ready", host_tx_ready, 0);
         chk("rst_child_rx_ready", child_rx_ready, '0);
         chk("rst_dest_error", dest_error, 0);
      end else begin
         for (int i = 0; i < NC; i++) begin
            chk($sformatf("lane%0d_valid", i + 1), child_tx_valid[i], m_lv[i]);
            if (m_lv[i]) chk($sformatf("lane%0d_data", i + 1), child_tx_data[i*64 +: 64], m_ld[i]);
         end
         chk("host_rx_valid", host_rx_valid, m_ov);
         if (m_ov) chk("host_rx_data", host_rx_data, m_od);
         chk("dest_error", dest_error, m_derr);
         e_all = 1'b1;
         for (int i = 0; i < NC; i++) begin
            e_free[i] = !m_lv[i] || child_tx_ready[i];
            e_all &= e_free[i];
         end
         e_d   = int'(host_tx_data[55:48]);
         e_htr = (e_d == 255) ? e_all : (e_d >= 1 && e_d <= NC) ? e_free[e_d-1] : 1'b1;
         chk("host_tx_ready", host_tx_ready, e_htr);
         e_can  = !m_ov || host_rx_ready;
         e_emit = e_can;
         for (int i = 0; i < NC; i++) e_emit &= m_rep[i];
         e_g = -1;
         if (e_can && !e_emit)
            for (int k = 1; k <= NC; k++) begin
               e_c = (m_last + k) % NC;
               if (e_g < 0 && child_rx_valid[e_c] &&
                   !(child_rx_data[e_c*64+56 +: 8] == 8'h04 && m_rep[e_c])) e_g = e_c;
            end
         e_crr = '0;
         if (e_g >= 0) e_crr[e_g] = 1'b1;
         chk("child_rx_ready", child_rx_ready, e_crr);
         for (int i = 0; i < NC; i++) if (m_lv[i] && child_tx_ready[i]) m_lv[i] = 1'b0;
         e_fire = host_tx_valid && e_htr;
         m_derr = e_fire && !(e_d == 255 || (e_d >= 1 && e_d <= NC));
         if (e_fire)
            for (int i = 0; i < NC; i++)
               if (e_d == 255 || e_d == i + 1) begin
                  m_lv[i] = 1'b1;
                  m_ld[i] = host_tx_data;
               end
         if (m_ov && host_rx_ready) m_ov = 1'b0;
         if (e_emit) begin
            m_ov = 1'b1;
            m_od = {8'h04, 55'b0, m_acc};
            m_acc = 1'b0;
            for (int i = 0; i < NC; i++) m_rep[i] = 1'b0;
         end else if (e_g >= 0) begin
            m_last = e_g;
            m_w = child_rx_data[e_g*64 +: 64];
            if (m_w[63:56] == 8'h04) begin
               m_rep[e_g] = 1'b1;
               m_acc |= m_w[0];
            end else begin
               m_ov = 1'b1;
               m_od = m_w;
            end
         end
      end
   end

   task automatic drive();
      host_tx_valid = hq.size() != 0;
      host_tx_data  = hq.size() != 0 ? hq[0] : '0;
      for (int i = 0; i < NC; i++) begin
         child_rx_valid[i]        = cq[i].size() != 0;
         child_rx_data[i*64 +: 64] = cq[i].size() != 0 ? cq[i][0] : '0;
      end
   endtask

   task automatic tick();
      logic          hh;
      logic [NC-1:0] hc;
      @(negedge clk); #1;
      hh = host_tx_valid && host_tx_ready;
      hc = child_rx_valid & child_rx_ready;
      if (host_rx_valid && host_rx_ready) rx_q.push_back(host_rx_data);
      @(posedge clk); #1;
      if (hh) void'(hq.pop_front());
      for (int i = 0; i < NC; i++) if (hc[i]) void'(cq[i].pop_front());
      drive();
   endtask

   function automatic bit busy();
      bit b = hq.size() != 0;
      for (int i = 0; i < NC; i++) b |= cq[i].size() != 0;
      return b;
   endfunction

   task automatic run();
      int n = 0;
      while (busy() && n < 300) begin
         tick();
         n++;
      end
      chk("queues_drained_in_time", busy(), 0);
   endtask

   initial begin
      host_rx_ready  = 1'b1;
      child_tx_ready = '1;
      drive();
      repeat (2) @(posedge clk);
      #1;
      host_tx_valid = 1'b1;
      host_tx_data  = 64'h0102_0000_0000_0001;
      child_rx_valid = 4'b0001;
      child_rx_data[63:0] = 64'h0100_0100_0000_0000;
      #1;
      chk("lit_rst_host_tx_ready", host_tx_ready, 0);
      chk("lit_rst_child_rx_ready", child_rx_ready, 0);
      chk("lit_rst_child_tx_valid", child_tx_valid, 0);
      chk("lit_rst_host_rx_valid", host_rx_valid, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      drive();

      hq.push_back(64'h0102_0000_0000_1234);
      drive(); run(); #1;
      chk("uni_valid", child_tx_valid, 4'b0010);
      chk("uni_data", child_tx_data[127:64], 64'h0102_0000_0000_1234);
      tick(); #1;
      chk("uni_clear", child_tx_valid, 0);

      child_tx_ready = 4'b1011;
      hq.push_back(64'h0103_0000_0000_0033);
      drive(); run();
      hq.push_back(64'h01FF_0000_0000_00BB);
      drive();
      repeat (3) tick();
      #1;
      chk("bc_blocked_ready", host_tx_ready, 0);
      chk("bc_slot3_held", child_tx_valid, 4'b0100);
      child_tx_ready = 4'hF;
      run(); #1;
      chk("bc_all_valid", child_tx_valid, 4'hF);
      for (int i = 0; i < NC; i++)
         chk($sformatf("bc_lane%0d_data", i + 1), child_tx_data[i*64 +: 64], 64'h01FF_0000_0000_00BB);
      tick();

      hq.push_back(64'h0107_0000_0000_0077);
      drive(); run(); #1;
      chk("inv_dest_error", dest_error, 1);
      chk("inv_no_lane", child_tx_valid, 0);
      tick(); #1;
      chk("inv_dest_error_pulse", dest_error, 0);

      rx_q.delete();
      for (int i = 0; i < NC; i++)
         for (int j = 0; j < 3; j++) cq[i].push_back({8'h01, 8'h00, 8'(i + 1), 40'(j)});
      drive(); run();
      repeat (3) tick();
      chk("rr_count", rx_q.size(), 12);
      for (int k = 0; k < 8; k++)
         chk($sformatf("rr_src%0d", k), rx_q.size() > k ? rx_q[k][47:40] : 8'hxx, rr_exp[k]);

      rx_q.delete();
      cq[0].push_back(agg(1, 0));
      cq[0].push_back(agg(1, 0));
      cq[1].push_back(agg(2, 0));
      cq[2].push_back(agg(3, 1));
      cq[3].push_back(agg(4, 0));
      drive(); tick(); #1;
      chk("agg_second_report_stalled", child_rx_ready[0], 0);
      run();
      repeat (3) tick();
      chk("agg_count", rx_q.size(), 1);
      chk("agg_word", rx_q.size() > 0 ? rx_q[0] : 64'hx, 64'h0400_0000_0000_0001);

      cq[1].push_back(agg(2, 1));
      drive(); run();
      child_tx_ready = '0;
      hq.push_back(64'h01FF_0000_0000_00CC);
      drive(); run(); #1;
      chk("mid_slots_full", child_tx_valid, 4'hF);
      host_rx_ready = 1'b0;
      cq[2].push_back(64'h0100_0300_0000_0055);
      drive(); tick(); #1;
      chk("mid_out_full", host_rx_valid, 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_child_tx_valid", child_tx_valid, 0);
      chk("mid_rst_host_rx_valid", host_rx_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      child_tx_ready = '1;
      host_rx_ready  = 1'b1;
      rx_q.delete();
      for (int i = 0; i < 3; i++) cq[i].push_back(agg(i + 1, 0));
      drive(); run();
      repeat (3) tick();
      chk("fresh_no_agg_after_three", rx_q.size(), 0);
      cq[3].push_back(agg(4, 0));
      drive(); run();
      repeat (3) tick();
      chk("fresh_agg_count", rx_q.size(), 1);
      chk("fresh_agg_word", rx_q.size() > 0 ? rx_q[0] : 64'hx, 64'h0400_0000_0000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end
endmodule
